// File: rtl/ber_stat_pkg.sv
// Shared definitions for the BER statistics logger.
//   - Default widths and counts used as parameter defaults by the logger and
//     its popcount sub-module.
//   - Result word layout: {err_acc, snr_tag}, error total in the upper
//     ERR_ACC_W bits and the SNR tag in the lower SNR_W bits (bits [31:4] and
//     [3:0] for the default widths).
//   - FSM state encoding for the warm-up / accumulate controller.
package ber_stat_pkg;

  localparam int BER_N             = 204;
  localparam int BER_ERR_ACC_W     = 28;
  localparam int BER_SNR_W         = 4;
  localparam int BER_BLK_CNT_W     = 20;
  localparam int BER_WARMUP_BLOCKS = 4;
  localparam int BER_REPORT_PERIOD = 16;

  typedef enum logic {
    S_WARMUP = 1'b0,
    S_ACCUM  = 1'b1
  } ber_state_e;

endpackage

// File: rtl/errbit_popcount.sv
// Three-stage pipelined popcount of a decoder hard-decision frame.
// The SNR tag and a valid flag travel alongside the count, so a result leaves
// the pipeline three cycles after its frame strobe. A new frame is accepted
// every cycle; there is no backpressure.
// Ports:
//   clk_i   : clock, rising edge
//   rstn_i  : synchronous active-low reset (clears the valid pipeline only)
//   frame_i : hard decision bits, 1 = bit error
//   vld_i   : frame strobe
//   snr_i   : SNR tag sampled with the strobe
//   vld_o   : count valid
//   cnt_o   : number of ones in the frame
//   snr_o   : SNR tag belonging to cnt_o
module errbit_popcount
  import ber_stat_pkg::*;
#(
  parameter int N         = BER_N,
  parameter int SNR_WIDTH = BER_SNR_W,
  parameter int CNT_W     = $clog2(N + 1)
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N-1:0]         frame_i,
  input  logic                 vld_i,
  input  logic [SNR_WIDTH-1:0] snr_i,
  output logic                 vld_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [SNR_WIDTH-1:0] snr_o
);

  // The frame is padded to a whole number of 64-bit blocks so every stage-2
  // adder sees exactly eight byte groups; padding groups are constant zero.
  localparam int G2   = (N + 63) / 64;
  localparam int G1   = G2 * 8;
  localparam int PADW = G1 * 8;

  logic [PADW-1:0]      frame_pad;
  logic [3:0]           grp_d  [G1];
  logic [3:0]           grp_p0 [G1];
  logic [CNT_W-1:0]     part_d  [G2];
  logic [CNT_W-1:0]     part_p1 [G2];
  logic [CNT_W-1:0]     cnt_d;
  logic [CNT_W-1:0]     cnt_p2;
  logic [SNR_WIDTH-1:0] snr_p0, snr_p1, snr_p2;
  logic                 vld_p0, vld_p1, vld_p2;

  assign frame_pad = PADW'(frame_i);

  always_comb begin
    for (int g = 0; g < G1; g++) begin
      grp_d[g] = '0;
      for (int b = 0; b < 8; b++) begin
        grp_d[g] = grp_d[g] + {3'b000, frame_pad[g*8+b]};
      end
    end
  end

  always_comb begin
    for (int p = 0; p < G2; p++) begin
      part_d[p] = '0;
      for (int j = 0; j < 8; j++) begin
        part_d[p] = part_d[p] + CNT_W'(grp_p0[p*8+j]);
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int p = 0; p < G2; p++) begin
      cnt_d = cnt_d + part_p1[p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= vld_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    // stage p0: byte-group sums
    grp_p0  <= grp_d;
    snr_p0  <= snr_i;
    // stage p1: eight-group partial sums
    part_p1 <= part_d;
    snr_p1  <= snr_p0;
    // stage p2: frame total
    cnt_p2  <= cnt_d;
    snr_p2  <= snr_p1;
  end

  assign vld_o = vld_p2;
  assign cnt_o = cnt_p2;
  assign snr_o = snr_p2;

endmodule

// File: rtl/ber_stat_logger.sv
// BER statistics logger behind the LDPC decoder. Each decoded frame (all-zero
// codeword sent) has its bit errors counted; frames after reset or an SNR
// change are discarded as warm-up, the rest are accumulated, and every
// REPORT_PERIOD accumulated frames a {err_acc, snr} word goes to the PS FIFO.
// Ports:
//   sys_clk          : clock, rising edge
//   rstn             : synchronous active-low reset
//   hard_frame       : decoder hard decision, 1 = bit error
//   frame_valid      : one-cycle frame strobe
//   snr_packet       : SNR index sampled with frame_valid
//   result_fifo_full : PS FIFO full, suppresses writes
//   result_fifo_in   : last written {err_acc, snr_tag}
//   result_fifo_we   : one-cycle write strobe
//   blk_cnt          : accumulated frames since last SNR change
//   err_acc          : accumulated bit errors (saturating)
//   report_drop      : sticky, a report was lost while another was pending
module ber_stat_logger
  import ber_stat_pkg::*;
#(
  parameter int N             = BER_N,
  parameter int ERR_ACC_WIDTH = BER_ERR_ACC_W,
  parameter int SNR_WIDTH     = BER_SNR_W,
  parameter int BLK_CNT_WIDTH = BER_BLK_CNT_W,
  parameter int WARMUP_BLOCKS = BER_WARMUP_BLOCKS,
  parameter int REPORT_PERIOD = BER_REPORT_PERIOD
) (
  input  logic                               sys_clk,
  input  logic                               rstn,
  input  logic [N-1:0]                       hard_frame,
  input  logic                               frame_valid,
  input  logic [SNR_WIDTH-1:0]               snr_packet,
  input  logic                               result_fifo_full,
  output logic [ERR_ACC_WIDTH+SNR_WIDTH-1:0] result_fifo_in,
  output logic                               result_fifo_we,
  output logic [BLK_CNT_WIDTH-1:0]           blk_cnt,
  output logic [ERR_ACC_WIDTH-1:0]           err_acc,
  output logic                               report_drop
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int WW    = (WARMUP_BLOCKS < 1) ? 1 : $clog2(WARMUP_BLOCKS + 1);
  localparam int RW    = ERR_ACC_WIDTH + SNR_WIDTH;

  logic                     vld_p2;
  logic [CNT_W-1:0]         cnt_p2;
  logic [SNR_WIDTH-1:0]     snr_p2;

  ber_state_e               state_q, state_d;
  logic [ERR_ACC_WIDTH-1:0] err_q, err_d;
  logic [BLK_CNT_WIDTH-1:0] blk_q, blk_d;
  logic [WW-1:0]            warm_q, warm_d;
  logic [SNR_WIDTH-1:0]     snr_q, snr_d;
  logic                     rpt_vld;
  logic [RW-1:0]            rpt_word;
  logic                     pend_q, pend_d;
  logic [RW-1:0]            pend_word_q, pend_word_d;
  logic                     we_q, we_d;
  logic [RW-1:0]            fifo_q, fifo_d;
  logic                     drop_q, drop_d;

  function automatic logic [ERR_ACC_WIDTH-1:0] sat_add_err(
    input logic [ERR_ACC_WIDTH-1:0] acc,
    input logic [CNT_W-1:0]         inc
  );
    logic [ERR_ACC_WIDTH:0] sum;
    sum = {1'b0, acc} + {{(ERR_ACC_WIDTH + 1 - CNT_W){1'b0}}, inc};
    return sum[ERR_ACC_WIDTH] ? '1 : sum[ERR_ACC_WIDTH-1:0];
  endfunction

  function automatic logic [BLK_CNT_WIDTH-1:0] sat_inc_blk(
    input logic [BLK_CNT_WIDTH-1:0] cnt
  );
    return (cnt == '1) ? cnt : cnt + BLK_CNT_WIDTH'(1);
  endfunction

  errbit_popcount #(
    .N        (N),
    .SNR_WIDTH(SNR_WIDTH),
    .CNT_W    (CNT_W)
  ) u_popcount (
    .clk_i  (sys_clk),
    .rstn_i (rstn),
    .frame_i(hard_frame),
    .vld_i  (frame_valid),
    .snr_i  (snr_packet),
    .vld_o  (vld_p2),
    .cnt_o  (cnt_p2),
    .snr_o  (snr_p2)
  );

  // A result carrying a new SNR tag restarts the statistics and is itself
  // the first warm-up frame.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    blk_d   = blk_q;
    warm_d  = warm_q;
    snr_d   = snr_q;
    rpt_vld = 1'b0;
    if (vld_p2) begin
      if (snr_p2 != snr_q) begin
        snr_d   = snr_p2;
        err_d   = '0;
        blk_d   = '0;
        warm_d  = WW'(1);
        state_d = (WARMUP_BLOCKS <= 1) ? S_ACCUM : S_WARMUP;
      end else begin
        unique case (state_q)
          S_WARMUP: begin
            warm_d = warm_q + WW'(1);
            if (warm_d == WW'(WARMUP_BLOCKS)) state_d = S_ACCUM;
          end
          S_ACCUM: begin
            err_d = sat_add_err(err_q, cnt_p2);
            blk_d = sat_inc_blk(blk_q);
            if ((int'(blk_d) % REPORT_PERIOD) == 0) rpt_vld = 1'b1;
          end
          default: state_d = S_WARMUP;
        endcase
      end
    end
    rpt_word = {err_d, snr_q};
  end

  // One pending slot: a pending word always goes out first, and a new report
  // only replaces it in the cycle the pending word is written.
  always_comb begin
    we_d        = 1'b0;
    fifo_d      = fifo_q;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;
    drop_d      = drop_q;
    if (pend_q) begin
      if (!result_fifo_full) begin
        we_d   = 1'b1;
        fifo_d = pend_word_q;
        pend_d = rpt_vld;
        if (rpt_vld) pend_word_d = rpt_word;
      end else if (rpt_vld) begin
        drop_d = 1'b1;
      end
    end else if (rpt_vld) begin
      if (!result_fifo_full) begin
        we_d   = 1'b1;
        fifo_d = rpt_word;
      end else begin
        pend_d      = 1'b1;
        pend_word_d = rpt_word;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state_q <= S_WARMUP;
      err_q   <= '0;
      blk_q   <= '0;
      warm_q  <= '0;
      snr_q   <= '0;
      pend_q  <= 1'b0;
      we_q    <= 1'b0;
      fifo_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      blk_q   <= blk_d;
      warm_q  <= warm_d;
      snr_q   <= snr_d;
      pend_q  <= pend_d;
      we_q    <= we_d;
      fifo_q  <= fifo_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    pend_word_q <= pend_word_d;
  end

  assign result_fifo_in = fifo_q;
  assign result_fifo_we = we_q;
  assign blk_cnt        = blk_q;
  assign err_acc        = err_q;
  assign report_drop    = drop_q;

endmodule

// File: tb/tb_ber_stat_logger.sv
module tb_ber_stat_logger;

  localparam int N   = 204;
  localparam int SW  = 4;
  localparam int EWA = 28;
  localparam int EWB = 10;
  localparam int BW  = 20;
  localparam int WU  = 4;
  localparam int RPA = 1;
  localparam int RPB = 16;

  logic           clk         = 1'b0;
  logic           rstn        = 1'b0;
  logic [N-1:0]   hard_frame  = '0;
  logic           frame_valid = 1'b0;
  logic [SW-1:0]  snr_packet  = '0;
  logic           fifo_full   = 1'b0;

  logic [EWA+SW-1:0] a_word;
  logic              a_we;
  logic [BW-1:0]     a_blk;
  logic [EWA-1:0]    a_err;
  logic              a_drop;
  logic [EWB+SW-1:0] b_word;
  logic              b_we;
  logic [BW-1:0]     b_blk;
  logic [EWB-1:0]    b_err;
  logic              b_drop;

  ber_stat_logger #(
    .N(N), .ERR_ACC_WIDTH(EWA), .SNR_WIDTH(SW), .BLK_CNT_WIDTH(BW),
    .WARMUP_BLOCKS(WU), .REPORT_PERIOD(RPA)
  ) dut_a (
    .sys_clk(clk), .rstn(rstn), .hard_frame(hard_frame), .frame_valid(frame_valid),
    .snr_packet(snr_packet), .result_fifo_full(fifo_full), .result_fifo_in(a_word),
    .result_fifo_we(a_we), .blk_cnt(a_blk), .err_acc(a_err), .report_drop(a_drop)
  );

  ber_stat_logger #(
    .N(N), .ERR_ACC_WIDTH(EWB), .SNR_WIDTH(SW), .BLK_CNT_WIDTH(BW),
    .WARMUP_BLOCKS(WU), .REPORT_PERIOD(RPB)
  ) dut_b (
    .sys_clk(clk), .rstn(rstn), .hard_frame(hard_frame), .frame_valid(frame_valid),
    .snr_packet(snr_packet), .result_fifo_full(fifo_full), .result_fifo_in(b_word),
    .result_fifo_we(b_we), .blk_cnt(b_blk), .err_acc(b_err), .report_drop(b_drop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { longint cyc; int cnt; int snr; } fr_t;
  fr_t    pipe_q[$];
  fr_t    cur_r;
  bit     have_r;
  longint cyc_n = 0;
  longint m_err[2], m_blk[2], m_warm[2], m_snr[2], m_pw[2], m_word[2];
  bit     m_acc[2], m_pend[2], m_we[2], m_drop[2];
  bit     model_on = 1'b0;

  function automatic longint emax(int k);
    return (k == 0) ? ((64'd1 << EWA) - 1) : ((64'd1 << EWB) - 1);
  endfunction

  function automatic int rper(int k);
    return (k == 0) ? RPA : RPB;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_blk[k] = 0; m_warm[k] = 0; m_snr[k] = 0; m_pw[k] = 0;
      m_word[k] = 0; m_acc[k] = 1'b0; m_pend[k] = 1'b0; m_we[k] = 1'b0; m_drop[k] = 1'b0;
    end
  endtask

  task automatic m_step(int k, bit have, int cnt, int snr);
    bit     formed;
    longint nw;
    formed = 1'b0;
    nw     = 0;
    if (have) begin
      if (longint'(snr) != m_snr[k]) begin
        m_snr[k] = snr; m_err[k] = 0; m_blk[k] = 0; m_warm[k] = 1;
        m_acc[k] = (WU <= 1);
      end else if (!m_acc[k]) begin
        m_warm[k]++;
        if (m_warm[k] >= WU) m_acc[k] = 1'b1;
      end else begin
        m_err[k] = m_err[k] + cnt;
        if (m_err[k] > emax(k)) m_err[k] = emax(k);
        if (m_blk[k] < ((64'd1 << BW) - 1)) m_blk[k]++;
        if ((m_blk[k] % rper(k)) == 0) begin
          formed = 1'b1;
          nw     = (m_err[k] << SW) | m_snr[k];
        end
      end
    end
    m_we[k] = 1'b0;
    if (m_pend[k]) begin
      if (!fifo_full) begin
        m_we[k] = 1'b1; m_word[k] = m_pw[k];
        m_pend[k] = formed;
        if (formed) m_pw[k] = nw;
      end else if (formed) begin
        m_drop[k] = 1'b1;
      end
    end else if (formed) begin
      if (!fifo_full) begin m_we[k] = 1'b1; m_word[k] = nw; end
      else begin m_pend[k] = 1'b1; m_pw[k] = nw; end
    end
  endtask

  // Each frame's error count becomes visible to the statistics three edges
  // after the edge that sampled it.
  initial forever begin
    @(posedge clk);
    cyc_n++;
    if (!rstn) begin
      m_reset();
      pipe_q.delete();
      model_on = 1'b1;
    end else begin
      have_r = 1'b0;
      cur_r  = '{cyc: 0, cnt: 0, snr: 0};
      if (pipe_q.size() > 0 && pipe_q[0].cyc == cyc_n - 3) begin
        cur_r  = pipe_q.pop_front();
        have_r = 1'b1;
      end
      for (int k = 0; k < 2; k++) m_step(k, have_r, cur_r.cnt, cur_r.snr);
      if (frame_valid)
        pipe_q.push_back('{cyc: cyc_n, cnt: $countones(hard_frame), snr: int'(snr_packet)});
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("A.we",   longint'(a_we),   longint'(m_we[0]));
      chk("A.word", longint'(a_word), m_word[0]);
      chk("A.blk",  longint'(a_blk),  m_blk[0]);
      chk("A.err",  longint'(a_err),  m_err[0]);
      chk("A.drop", longint'(a_drop), longint'(m_drop[0]));
      chk("B.we",   longint'(b_we),   longint'(m_we[1]));
      chk("B.word", longint'(b_word), m_word[1]);
      chk("B.blk",  longint'(b_blk),  m_blk[1]);
      chk("B.err",  longint'(b_err),  m_err[1]);
      chk("B.drop", longint'(b_drop), longint'(m_drop[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(bit v, logic [N-1:0] f, logic [SW-1:0] s);
    frame_valid = v;
    hard_frame  = f;
    snr_packet  = s;
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] ones(int n);
    logic [N-1:0] f;
    f = '0;
    for (int i = 0; i < n; i++) f[(i * 41) % N] = 1'b1;
    return f;
  endfunction

  function automatic logic [N-1:0] rand_frame(int kind);
    logic [N-1:0] f;
    f = '0;
    case (kind)
      0: f = '0;
      1: for (int i = 0; i < N; i++) f[i] = ($urandom_range(31) == 0);
      2: for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(1));
      default: f = '1;
    endcase
    return f;
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) tick(1'b0, '0, 4'd0);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SW-1:0] snr_r;
    int            kind;
    @(negedge clk);
    do_reset();
    chk("rst.we",   longint'(a_we),   0);
    chk("rst.word", longint'(a_word), 0);
    chk("rst.blk",  longint'(a_blk),  0);
    chk("rst.err",  longint'(a_err),  0);
    chk("rst.drop", longint'(a_drop), 0);

    // warm-up then first report with REPORT_PERIOD=1
    repeat (4) tick(1'b1, '0, 4'd10);
    tick(1'b1, ones(5), 4'd10);
    repeat (3) tick(1'b0, '0, 4'd10);
    chk("T1.we",   longint'(a_we),   1);
    chk("T1.word", longint'(a_word), 64'h5A);
    chk("T1.blk",  longint'(a_blk),  1);

    // back-to-back frames
    do_reset();
    repeat (8) tick(1'b1, ones(3), 4'd10);
    repeat (3) tick(1'b0, '0, 4'd10);
    chk("T2.errA", longint'(a_err), 12);
    chk("T2.errB", longint'(b_err), 12);
    chk("T2.blkA", longint'(a_blk), 4);
    chk("T2.word", longint'(a_word), 64'hCA);

    // FIFO full at report time
    fifo_full = 1'b1;
    tick(1'b1, ones(3), 4'd10);
    repeat (10) tick(1'b0, '0, 4'd10);
    chk("T3.hold_we",   longint'(a_we),   0);
    chk("T3.hold_word", longint'(a_word), 64'hCA);
    fifo_full = 1'b0;
    tick(1'b0, '0, 4'd10);
    chk("T3.we",   longint'(a_we),   1);
    chk("T3.word", longint'(a_word), 64'hFA);

    // second report while first pending
    fifo_full = 1'b1;
    tick(1'b1, ones(3), 4'd10);
    tick(1'b1, ones(3), 4'd10);
    repeat (5) tick(1'b0, '0, 4'd10);
    chk("T4.drop", longint'(a_drop), 1);
    fifo_full = 1'b0;
    tick(1'b0, '0, 4'd10);
    chk("T4.we",   longint'(a_we),   1);
    chk("T4.word", longint'(a_word), 64'h12A);
    tick(1'b0, '0, 4'd10);
    chk("T4.we_after", longint'(a_we), 0);
    chk("T4.err", longint'(a_err), 21);

    // SNR change 10 -> 9
    repeat (4) tick(1'b1, ones(1), 4'd9);
    chk("T5.err_clr", longint'(a_err), 0);
    chk("T5.blk_clr", longint'(a_blk), 0);
    tick(1'b1, ones(1), 4'd9);
    repeat (3) tick(1'b0, '0, 4'd9);
    chk("T5.err",  longint'(a_err),  1);
    chk("T5.word", longint'(a_word), 64'h19);

    // saturation on the narrow instance, then reset mid-pipeline
    do_reset();
    repeat (10) tick(1'b1, '1, 4'd3);
    repeat (3) tick(1'b0, '0, 4'd3);
    chk("T6.errB", longint'(b_err), 64'h3FF);
    chk("T6.errA", longint'(a_err), 1224);
    tick(1'b1, ones(5), 4'd3);
    rstn = 1'b0;
    tick(1'b1, ones(5), 4'd3);
    rstn = 1'b1;
    repeat (6) begin
      tick(1'b0, '0, 4'd3);
      chk("T6.no_write", longint'(a_we), 0);
    end
    chk("T6.blk", longint'(a_blk), 0);

    // randomized traffic
    snr_r = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) snr_r = 4'($urandom_range(3));
      if (fifo_full) fifo_full = ($urandom_range(3) != 0);
      else           fifo_full = ($urandom_range(19) == 0);
      rstn = ($urandom_range(699) != 0);
      kind = int'($urandom_range(9));
      kind = (kind < 2) ? 0 : (kind < 7) ? 1 : (kind < 9) ? 2 : 3;
      tick(1'($urandom_range(1)), rand_frame(kind), snr_r);
    end
    rstn      = 1'b1;
    fifo_full = 1'b0;
    repeat (10) tick(1'b0, '0, snr_r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
